// File: rtl/braille_cell_encoder_if.sv
// Handshake bundle between the dot front end, the braille cell encoder and the code consumer.
interface braille_cell_encoder_if;
  logic       dot_in;
  logic       dot_valid;
  logic       dot_ready;
  logic       abort;
  logic [3:0] code_out;
  logic       code_err;
  logic       code_valid;
  logic       code_ready;
  logic       busy;
  logic [2:0] dot_count;

  modport master (
    output dot_in, dot_valid, abort, code_ready,
    input  dot_ready, code_out, code_err, code_valid, busy, dot_count
  );

  modport slave (
    input  dot_in, dot_valid, abort, code_ready,
    output dot_ready, code_out, code_err, code_valid, busy, dot_count
  );
endinterface

// File: rtl/braille_cell_encoder.sv
// Serially collects one 6-dot braille cell (first dot = pattern bit 5) and encodes it
// to a 4-bit code 0..14; unknown patterns and inter-dot timeouts report code 15 with error.
//
// state   | meaning
// IDLE    | waiting for the first dot of a cell
// COLLECT | dots 1..5 received, inter-dot timer running
// LOOKUP  | all 6 dots in, encoding the pattern (one cycle)
// HOLD    | result presented until the consumer takes it
module braille_cell_encoder #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMER_W        = 26
) (
  input logic                   i_clk,
  input logic                   i_reset,
  braille_cell_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, LOOKUP, HOLD} state_t;

  localparam logic [TIMER_W-1:0] TC_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [5:0]         r_shift;
  logic [2:0]         r_dot_count;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_code_out;
  logic               r_code_err;
  logic               r_code_valid;

  logic w_dot_ready;
  logic w_accept;
  logic w_timeout;
  logic w_handshake;

  function automatic logic [4:0] encode(input logic [5:0] pat);
    case (pat)
      6'b000111: encode = 5'b0_0000;
      6'b001000: encode = 5'b0_0001;
      6'b001010: encode = 5'b0_0010;
      6'b001100: encode = 5'b0_0011;
      6'b001101: encode = 5'b0_0100;
      6'b001001: encode = 5'b0_0101;
      6'b001110: encode = 5'b0_0110;
      6'b001111: encode = 5'b0_0111;
      6'b001011: encode = 5'b0_1000;
      6'b000101: encode = 5'b0_1001;
      6'b010011: encode = 5'b0_1010;
      6'b000011: encode = 5'b0_1011;
      6'b100001: encode = 5'b0_1100;
      6'b010010: encode = 5'b0_1101;
      6'b111111: encode = 5'b0_1110;
      default:   encode = 5'b1_1111;
    endcase
  endfunction

  assign w_dot_ready = (r_state == IDLE) || (r_state == COLLECT);
  assign w_accept    = bus.dot_valid && w_dot_ready;
  // A dot arriving on the final timer cycle still counts, so timeout requires no accept.
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_state == COLLECT) && !w_accept
                       && (r_timer == TC_LAST);
  assign w_handshake = (r_state == HOLD) && r_code_valid && bus.code_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_dot_count  <= '0;
      r_timer      <= '0;
      r_code_out   <= '0;
      r_code_err   <= 1'b0;
      r_code_valid <= 1'b0;
    end else if (bus.abort) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_dot_count  <= '0;
      r_timer      <= '0;
      r_code_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift     <= {r_shift[4:0], bus.dot_in};
            r_dot_count <= r_dot_count + 3'd1;
            r_timer     <= '0;
            r_state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_timeout) begin
            r_code_out   <= 4'd15;
            r_code_err   <= 1'b1;
            r_code_valid <= 1'b1;
            r_state      <= HOLD;
          end else if (w_accept) begin
            r_shift     <= {r_shift[4:0], bus.dot_in};
            r_dot_count <= r_dot_count + 3'd1;
            r_timer     <= '0;
            if (r_dot_count == 3'd5) r_state <= LOOKUP;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        LOOKUP: begin
          {r_code_err, r_code_out} <= encode(r_shift);
          r_code_valid             <= 1'b1;
          r_state                  <= HOLD;
        end
        HOLD: begin
          if (w_handshake) begin
            r_code_valid <= 1'b0;
            r_shift      <= '0;
            r_dot_count  <= '0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dot_ready  = w_dot_ready;
  assign bus.code_out   = r_code_out;
  assign bus.code_err   = r_code_err;
  assign bus.code_valid = r_code_valid;
  assign bus.busy       = (r_state != IDLE);
  assign bus.dot_count  = r_dot_count;

endmodule

// File: tb/tb_braille_cell_encoder.sv
// Self-checking bench for braille_cell_encoder: code table, latency, backpressure,
// timeout, abort and asynchronous reset, with a result scoreboard.
module tb_braille_cell_encoder;

  typedef struct {
    logic [5:0] pat;
    logic [3:0] code;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t table_v[15];
  exp_t sb_q[$];

  braille_cell_encoder_if bus();

  braille_cell_encoder #(.TIMEOUT_CYCLES(8), .TIMER_W(4)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [5:0] pat);
    exp_t e;
    e.code = 4'd15;
    e.err  = 1'b1;
    for (int i = 0; i < 15; i++)
      if (table_v[i].pat == pat) begin
        e.code = table_v[i].code;
        e.err  = 1'b0;
      end
    return e;
  endfunction

  // Scoreboard: every result handshake pops one expected record.
  always @(negedge clk) begin
    if (!rst && bus.code_valid && bus.code_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got code %0d err %0b expected no result", bus.code_out, bus.code_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_code", 32'(bus.code_out), 32'(e.code));
        chk("sb_err", 32'(bus.code_err), 32'(e.err));
      end
    end
  end

  task automatic send_dot(input logic d);
    bus.dot_in    = d;
    bus.dot_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.dot_valid = 1'b0;
  endtask

  task automatic send_cell(input logic [5:0] pat);
    for (int b = 5; b >= 0; b--) send_dot(pat[b]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", name, bus.busy, n);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_dot_count"}, 32'(bus.dot_count), 0);
    chk({name, "_busy"}, 32'(bus.busy), 0);
    chk({name, "_dot_ready"}, 32'(bus.dot_ready), 1);
    chk({name, "_code_valid"}, 32'(bus.code_valid), 0);
    chk({name, "_code_out"}, 32'(bus.code_out), 0);
    chk({name, "_code_err"}, 32'(bus.code_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    table_v = '{
      '{6'b000111, 4'd0},  '{6'b001000, 4'd1},  '{6'b001010, 4'd2},
      '{6'b001100, 4'd3},  '{6'b001101, 4'd4},  '{6'b001001, 4'd5},
      '{6'b001110, 4'd6},  '{6'b001111, 4'd7},  '{6'b001011, 4'd8},
      '{6'b000101, 4'd9},  '{6'b010011, 4'd10}, '{6'b000011, 4'd11},
      '{6'b100001, 4'd12}, '{6'b010010, 4'd13}, '{6'b111111, 4'd14}};
    n_cmp = 0;
    n_err = 0;
    bus.dot_in     = 1'b0;
    bus.dot_valid  = 1'b0;
    bus.abort      = 1'b0;
    bus.code_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic cell 001111 -> 7 with one-cycle LOOKUP latency
    sb_q.push_back(model(6'b001111));
    send_cell(6'b001111);
    chk("t1_valid_lookup", 32'(bus.code_valid), 0);
    chk("t1_ready_lookup", 32'(bus.dot_ready), 0);
    chk("t1_count", 32'(bus.dot_count), 6);
    @(posedge clk);
    #1;
    chk("t1_valid", 32'(bus.code_valid), 1);
    chk("t1_code", 32'(bus.code_out), 7);
    chk("t1_err", 32'(bus.code_err), 0);
    wait_idle("t1");

    // Exhaustive pattern sweep through the scoreboard
    for (int p = 0; p < 64; p++) begin
      sb_q.push_back(model(6'(p)));
      send_cell(6'(p));
      wait_idle("sweep");
    end
    chk("sweep_drained", 32'(sb_q.size()), 0);

    // Backpressure with dot_valid held high in HOLD
    bus.code_ready = 1'b0;
    sb_q.push_back(model(6'b111111));
    send_cell(6'b111111);
    bus.dot_in    = 1'b0;
    bus.dot_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_code", 32'(bus.code_out), 14);
      chk("bp_dot_ready", 32'(bus.dot_ready), 0);
      chk("bp_count", 32'(bus.dot_count), 6);
    end
    chk("bp_valid", 32'(bus.code_valid), 1);
    bus.code_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.dot_valid = 1'b0;
    chk("bp_after_count", 32'(bus.dot_count), 0);
    chk("bp_after_busy", 32'(bus.busy), 0);
    chk("bp_after_valid", 32'(bus.code_valid), 0);
    chk("bp_after_code_kept", 32'(bus.code_out), 14);

    // Inter-dot timeout of 8 cycles
    bus.code_ready = 1'b0;
    send_dot(1'b1);
    send_dot(1'b0);
    e.code = 4'd15;
    e.err  = 1'b1;
    sb_q.push_back(e);
    repeat (7) @(posedge clk);
    #1;
    chk("to_valid_edge7", 32'(bus.code_valid), 0);
    @(posedge clk);
    #1;
    chk("to_valid_edge8", 32'(bus.code_valid), 1);
    chk("to_err", 32'(bus.code_err), 1);
    chk("to_code", 32'(bus.code_out), 15);
    bus.code_ready = 1'b1;
    wait_idle("to");

    // Abort wins over a same-cycle dot
    send_cell_partial: begin
      for (int b = 0; b < 4; b++) send_dot(1'b1);
    end
    chk("ab_count_before", 32'(bus.dot_count), 4);
    bus.dot_in    = 1'b1;
    bus.dot_valid = 1'b1;
    bus.abort     = 1'b1;
    @(posedge clk);
    #1;
    bus.dot_valid = 1'b0;
    bus.abort     = 1'b0;
    chk("ab_count", 32'(bus.dot_count), 0);
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_dot_ready", 32'(bus.dot_ready), 1);
    chk("ab_valid", 32'(bus.code_valid), 0);
    sb_q.push_back(model(6'b000011));
    send_cell(6'b000011);
    wait_idle("ab_recover");

    // Asynchronous reset mid-collect
    for (int b = 0; b < 3; b++) send_dot(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_collect");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset during HOLD
    bus.code_ready = 1'b0;
    send_cell(6'b000000);
    @(posedge clk);
    #1;
    chk("rst_hold_valid_before", 32'(bus.code_valid), 1);
    chk("rst_hold_err_before", 32'(bus.code_err), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.code_ready = 1'b1;

    // Recovery after reset
    sb_q.push_back(model(6'b100001));
    send_cell(6'b100001);
    wait_idle("final");
    repeat (2) @(posedge clk);
    #1;
    chk("final_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
